tri_fetch: RTL and testbench

- Parametrised successor of the fixed-size vertex/triangle source feeding the rasteriser.
- Walks a face table (3 vertex indices per triangle) and a vertex table (X,Y,Z per vertex), both held in external synchronous BRAMs with configurable read latency.
- Assembles each triangle and hands it downstream on a valid/ready handshake, then signals object completion.
- Sits between the model memories and the transform/raster pipeline.

---
 rtl/tri_fetch.sv | 162 ++++++++++++++++
 tb/tb_tri_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fetch.sv
// tri_fetch: walks the face table, gathers each triangle's three vertices from the vertex table, and
// streams the assembled triangles downstream. Define TRI_FETCH_BACKFACE_CULL_EN to drop clockwise/degenerate faces.
module tri_fetch #(
   parameter int COORD_W = 16,
   parameter int VERT_AW = 10,
   parameter int FACE_AW = 10,
   parameter int MEM_LAT = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [FACE_AW:0]     num_tris_in,
   output logic [FACE_AW-1:0]   face_addr_out,
   input  logic [3*VERT_AW-1:0] face_data_in,
   output logic [VERT_AW-1:0]   vert_addr_out,
   input  logic [3*COORD_W-1:0] vert_data_in,
   output logic [9*COORD_W-1:0] tri_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 obj_done_out,
   output logic                 busy_out,
   output logic [FACE_AW:0]     culled_cnt_out
);

   localparam int VW    = 3*COORD_W;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CAP0_CNT  = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CAP1_CNT  = CNT_W'(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] VERT_LAST = CNT_W'(MEM_LAT + 2);
   localparam logic [FACE_AW:0] ONE_TRI   = (FACE_AW+1)'(1);

   typedef enum logic [2:0] {
      IDLE,
      FACE,
      VERT,
`ifdef TRI_FETCH_BACKFACE_CULL_EN
      CULL,
`endif
      OUT,
      DONE
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt;
   logic [FACE_AW:0]     num_tris;
   logic [FACE_AW:0]     tri_idx;
   logic [3*VERT_AW-1:0] face_q;
   logic [VW-1:0]        v0, v1, v2;
   logic                 last_tri;

   assign last_tri      = (tri_idx + ONE_TRI) == num_tris;
   assign face_addr_out = tri_idx[FACE_AW-1:0];
   assign busy_out      = (state != IDLE);
   assign obj_done_out  = (state == DONE);

`ifdef TRI_FETCH_BACKFACE_CULL_EN
   localparam int AW = 2*COORD_W + 3;
   logic signed [AW-1:0] x0, y0, x1, y1, x2, y2, area;
   logic                 front_facing;
   logic [FACE_AW:0]     culled;

   assign x0 = AW'($signed(v0[COORD_W-1:0]));
   assign y0 = AW'($signed(v0[2*COORD_W-1:COORD_W]));
   assign x1 = AW'($signed(v1[COORD_W-1:0]));
   assign y1 = AW'($signed(v1[2*COORD_W-1:COORD_W]));
   assign x2 = AW'($signed(v2[COORD_W-1:0]));
   assign y2 = AW'($signed(v2[2*COORD_W-1:COORD_W]));
   // Positive area means counter-clockwise winding; zero (degenerate) is culled too.
   assign area           = (x1 - x0) * (y2 - y0) - (x2 - x0) * (y1 - y0);
   assign front_facing   = (area > 0);
   assign culled_cnt_out = culled;
`else
   assign culled_cnt_out = '0;
`endif

   always_comb begin
      // NOTE: every variable written here gets a default first so no path can infer a latch.
      state_d       = state;
      vert_addr_out = '0;
      unique case (state)
         IDLE: if (start_in) state_d = (num_tris_in == '0) ? DONE : FACE;
         FACE: if (cnt == CAP0_CNT) state_d = VERT;
         VERT: begin
            unique case (cnt)
               3'd0:    vert_addr_out = face_q[VERT_AW-1:0];
               3'd1:    vert_addr_out = face_q[2*VERT_AW-1:VERT_AW];
               3'd2:    vert_addr_out = face_q[3*VERT_AW-1:2*VERT_AW];
               default: vert_addr_out = '0;
            endcase
`ifdef TRI_FETCH_BACKFACE_CULL_EN
            if (cnt == VERT_LAST) state_d = CULL;
         end
         CULL: state_d = front_facing ? OUT : (last_tri ? DONE : FACE);
`else
            if (cnt == VERT_LAST) state_d = OUT;
         end
`endif
         OUT:  if (valid_out && ready_in) state_d = last_tri ? DONE : FACE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments throughout, and the synchronous reset clears every register
      // including the data path, so tri_out is zero until the first triangle after reset.
      if (!rst_n_in) begin
         state     <= IDLE;
         cnt       <= '0;
         num_tris  <= '0;
         tri_idx   <= '0;
         face_q    <= '0;
         v0        <= '0;
         v1        <= '0;
         v2        <= '0;
         tri_out   <= '0;
         valid_out <= 1'b0;
`ifdef TRI_FETCH_BACKFACE_CULL_EN
         culled    <= '0;
`endif
      end else begin
         state <= state_d;
         if (state_d != state)                  cnt <= '0;
         else if (state == FACE || state == VERT) cnt <= cnt + CNT_W'(1);

         unique case (state)
            IDLE: if (start_in) begin
               num_tris <= num_tris_in;
               tri_idx  <= '0;
`ifdef TRI_FETCH_BACKFACE_CULL_EN
               culled   <= '0;
`endif
            end
            FACE: if (cnt == CAP0_CNT) face_q <= face_data_in;
            VERT: begin
               // Each vertex arrives MEM_LAT cycles after its address was issued.
               if (cnt == CAP0_CNT)  v0 <= vert_data_in;
               if (cnt == CAP1_CNT)  v1 <= vert_data_in;
               if (cnt == VERT_LAST) v2 <= vert_data_in;
            end
`ifdef TRI_FETCH_BACKFACE_CULL_EN
            CULL: if (!front_facing) begin
               culled  <= culled + ONE_TRI;
               tri_idx <= tri_idx + ONE_TRI;
            end
`endif
            OUT: begin
               // First OUT cycle loads the output register; valid then holds until the handshake.
               if (!valid_out) begin
                  tri_out   <= {v2, v1, v0};
                  valid_out <= 1'b1;
               end else if (ready_in) begin
                  valid_out <= 1'b0;
                  tri_idx   <= tri_idx + ONE_TRI;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_fetch.sv
// tb_tri_fetch: drives two tri_fetch instances (MEM_LAT 2 and 4) from shared BRAM models and checks
// emitted triangles, handshake timing and object completion against a face-table reference model.
module tb_tri_fetch;

`ifdef TRI_FETCH_BACKFACE_CULL_EN
   localparam bit CULL_ON = 1'b1;
`else
   localparam bit CULL_ON = 1'b0;
`endif
   localparam int XTRA = CULL_ON ? 1 : 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [29:0] face_mem [1024];
   logic [47:0] vert_mem [1024];

   logic         start_s  [2];
   logic [10:0]  num_s    [2];
   logic         ready_s  [2];
   logic [9:0]   faddr_s  [2];
   logic [9:0]   vaddr_s  [2];
   logic [143:0] tri_s    [2];
   logic         valid_s  [2];
   logic         done_s   [2];
   logic         busy_s   [2];
   logic [10:0]  culled_s [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : 4;
      logic [29:0] fpipe [LAT];
      logic [47:0] vpipe [LAT];
      always @(posedge clk) begin
         fpipe[0] <= face_mem[faddr_s[g]];
         vpipe[0] <= vert_mem[vaddr_s[g]];
         for (int k = 1; k < LAT; k++) begin
            fpipe[k] <= fpipe[k-1];
            vpipe[k] <= vpipe[k-1];
         end
      end
      tri_fetch #(.MEM_LAT(LAT)) u_dut (
         .clk_in         (clk),
         .rst_n_in       (rst_n),
         .start_in       (start_s[g]),
         .num_tris_in    (num_s[g]),
         .face_addr_out  (faddr_s[g]),
         .face_data_in   (fpipe[LAT-1]),
         .vert_addr_out  (vaddr_s[g]),
         .vert_data_in   (vpipe[LAT-1]),
         .tri_out        (tri_s[g]),
         .valid_out      (valid_s[g]),
         .ready_in       (ready_s[g]),
         .obj_done_out   (done_s[g]),
         .busy_out       (busy_s[g]),
         .culled_cnt_out (culled_s[g])
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signed-area winding test straight from the vertex coordinates.
   function automatic bit front_facing(input logic [143:0] t);
      longint x[3], y[3];
      for (int k = 0; k < 3; k++) begin
         x[k] = longint'($signed(t[48*k +: 16]));
         y[k] = longint'($signed(t[48*k+16 +: 16]));
      end
      return ((x[1]-x[0])*(y[2]-y[0]) - (x[2]-x[0])*(y[1]-y[0])) > 0;
   endfunction

   function automatic logic [143:0] face_tri(input int f);
      logic [29:0] fc;
      fc = face_mem[f];
      return {vert_mem[fc[29:20]], vert_mem[fc[19:10]], vert_mem[fc[9:0]]};
   endfunction

   task automatic check_idle_zero(input int inst, input string tag);
      check($sformatf("%s_valid%0d", tag, inst), valid_s[inst], 0);
      check($sformatf("%s_done%0d", tag, inst), done_s[inst], 0);
      check($sformatf("%s_busy%0d", tag, inst), busy_s[inst], 0);
      check($sformatf("%s_tri%0d", tag, inst), tri_s[inst], 0);
      check($sformatf("%s_culled%0d", tag, inst), culled_s[inst], 0);
      check($sformatf("%s_faddr%0d", tag, inst), faddr_s[inst], 0);
      check($sformatf("%s_vaddr%0d", tag, inst), vaddr_s[inst], 0);
   endtask

   task automatic run_object(input int inst, input int n, input int stall_tri, input int stall_len,
                             input bit rnd, input int exp_first);
      logic [143:0] exp_q[$];
      logic [143:0] prev_tri;
      int  exp_culled = 0, emitted = 0, done_cnt = 0, done_edge = -1, first_edge = -1;
      int  stall_left = stall_len, stable_err = 0, gap_err = 0, edge_no = 0;
      bit  hs_pending = 0, held = 0, finished = 0;
      for (int f = 0; f < n; f++) begin
         if (CULL_ON && !front_facing(face_tri(f))) exp_culled++;
         else exp_q.push_back(face_tri(f));
      end
      @(negedge clk);
      num_s[inst]   = 11'(n);
      start_s[inst] = 1'b1;
      ready_s[inst] = 1'b1;
      @(negedge clk);
      start_s[inst] = 1'b0;
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         if (hs_pending && valid_s[inst]) gap_err++;
         if (held && (!valid_s[inst] || tri_s[inst] !== prev_tri)) stable_err++;
         if (valid_s[inst] && first_edge < 0) first_edge = edge_no;
         if (done_cnt > 0 && !done_s[inst]) begin
            check($sformatf("busy_after_done%0d", inst), busy_s[inst], 0);
            finished = 1;
         end
         if (done_s[inst]) begin
            if (done_cnt == 0) done_edge = edge_no;
            done_cnt++;
         end
         hs_pending = 0;
         if (valid_s[inst] && emitted == stall_tri && stall_left > 0) begin
            ready_s[inst] = 1'b0;
            stall_left--;
         end else begin
            ready_s[inst] = rnd ? 1'($urandom) : 1'b1;
         end
         held     = valid_s[inst] && !ready_s[inst];
         prev_tri = tri_s[inst];
         if (valid_s[inst] && ready_s[inst]) begin
            if (emitted < exp_q.size())
               check($sformatf("tri%0d_n%0d_k%0d", inst, n, emitted), tri_s[inst], exp_q[emitted]);
            emitted++;
            hs_pending = 1;
         end
         if (!finished) begin
            @(negedge clk);
            edge_no++;
         end
      end
      ready_s[inst] = 1'b1;
      check($sformatf("finished%0d_n%0d", inst, n), finished, 1);
      check($sformatf("handshakes%0d_n%0d", inst, n), emitted, exp_q.size());
      check($sformatf("done_pulses%0d_n%0d", inst, n), done_cnt, 1);
      check($sformatf("culled%0d_n%0d", inst, n), culled_s[inst], exp_culled);
      check($sformatf("stall_stable%0d_n%0d", inst, n), stable_err, 0);
      check($sformatf("valid_gap%0d_n%0d", inst, n), gap_err, 0);
      check($sformatf("first_valid_edge%0d_n%0d", inst, n), first_edge, exp_first);
      if (n == 0) check("empty_done_edge", done_edge, 0);
   endtask

   typedef struct {
      int inst;
      int n;
      int stall_tri;
      int stall_len;
      bit rnd;
      int exp_first;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{inst: 0, n: 0,  stall_tri: -1, stall_len: 0,  rnd: 0, exp_first: -1};
      vecs[1] = '{inst: 0, n: 1,  stall_tri: -1, stall_len: 0,  rnd: 0, exp_first: 9 + XTRA};
      vecs[2] = '{inst: 0, n: 3,  stall_tri: 1,  stall_len: 20, rnd: 0, exp_first: 9 + XTRA};
      vecs[3] = '{inst: 0, n: 2,  stall_tri: -1, stall_len: 0,  rnd: 0, exp_first: 9 + XTRA};
      vecs[4] = '{inst: 1, n: 1,  stall_tri: -1, stall_len: 0,  rnd: 0, exp_first: 13 + XTRA};
      vecs[5] = '{inst: 1, n: 6,  stall_tri: -1, stall_len: 0,  rnd: 1, exp_first: 13 + XTRA};
      vecs[6] = '{inst: 0, n: 12, stall_tri: 2,  stall_len: 5,  rnd: 1, exp_first: 9 + XTRA};

      for (int i = 0; i < 1024; i++) begin
         vert_mem[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
         face_mem[i] = {10'($urandom), 10'($urandom), 10'($urandom)};
      end
      vert_mem[0] = {16'sd0, 16'sd0,  16'sd0};
      vert_mem[1] = {16'sd0, 16'sd0,  16'sd10};
      vert_mem[2] = {16'sd0, 16'sd10, 16'sd0};
      face_mem[0] = {10'd2, 10'd1, 10'd0};   // counter-clockwise, area +100
      face_mem[1] = {10'd1, 10'd2, 10'd0};   // clockwise, area -100

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         num_s[i]   = '0;
         ready_s[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) check_idle_zero(i, "reset");
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++)
         run_object(vecs[v].inst, vecs[v].n, vecs[v].stall_tri, vecs[v].stall_len,
                    vecs[v].rnd, vecs[v].exp_first);

      // Start re-pulse during VERT, then reset during FACE of triangle 2.
      begin
         int edge_no = 0, first = -1, dones = 0;
         bit seen2 = 0;
         @(negedge clk);
         num_s[0]   = 11'd3;
         start_s[0] = 1'b1;
         ready_s[0] = 1'b1;
         @(negedge clk);
         start_s[0] = 1'b0;
         repeat (4) @(negedge clk);
         edge_no = 4;
         check("repulse_busy", busy_s[0], 1);
         num_s[0]   = 11'd0;
         start_s[0] = 1'b1;
         @(negedge clk);
         edge_no++;
         start_s[0] = 1'b0;
         for (int cyc = 0; cyc < 300; cyc++) begin
            if (valid_s[0] && first < 0) first = edge_no;
            if (done_s[0]) dones++;
            if (faddr_s[0] == 10'd2) begin
               seen2 = 1;
               break;
            end
            @(negedge clk);
            edge_no++;
         end
         check("repulse_first_valid", first, 9 + XTRA);
         check("repulse_no_done", dones, 0);
         check("reached_face2", seen2, 1);
         rst_n = 1'b0;
         @(negedge clk);
         check_idle_zero(0, "midreset");
         rst_n = 1'b1;
      end
      run_object(0, 1, -1, 0, 0, 9 + XTRA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
